// File: rtl/decoder_3of6_rx.sv
`default_nettype none
// ============================================================================
// Module   : decoder_3of6_rx
// Brief    : 3-of-6 receive decoder. Checks each 6-bit group for weight 3 and
//            recovers 3 payload bits per group behind a one-entry output register.
//            Optional error counter: define DECODER_3OF6_ERRCNT_EN.
// Revision : 1.0
// ============================================================================
module decoder_3of6_rx #(
    parameter int NUM_GROUPS = 8,
    parameter int DROP_ERR   = 0,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6*NUM_GROUPS-1:0] in_code,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [3*NUM_GROUPS-1:0] out_payload,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_err,
    output logic [NUM_GROUPS-1:0]   out_err_mask,
    output logic                    err_sticky,
`ifdef DECODER_3OF6_ERRCNT_EN
    output logic [CNT_W-1:0]        err_count,
`endif
    input  logic                    err_clr
);

    localparam bit c_DROP_EN = (DROP_ERR != 0);

    logic [NUM_GROUPS-1:0]   w_bad;
    logic [3*NUM_GROUPS-1:0] w_payload;
    logic                    w_accept;
    logic                    w_any_bad;
    logic                    w_bad_accept;
    logic                    w_load;

    logic                    r_valid;
    logic [3*NUM_GROUPS-1:0] r_payload;
    logic [NUM_GROUPS-1:0]   r_mask;
    logic                    r_sticky;

    generate
        if (NUM_GROUPS < 1 || CNT_W < 1) begin : g_param_check
            $error("decoder_3of6_rx: NUM_GROUPS and CNT_W must be at least 1");
        end

        for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
            logic [2:0] w_weight;

            assign w_weight = {2'b00, in_code[6*g+0]} + {2'b00, in_code[6*g+1]}
                            + {2'b00, in_code[6*g+2]} + {2'b00, in_code[6*g+3]}
                            + {2'b00, in_code[6*g+4]} + {2'b00, in_code[6*g+5]};
            assign w_bad[g]               = (w_weight != 3'd3);
            // Bad groups still forward their raw upper bits
            assign w_payload[3*g +: 3]    = in_code[6*g+3 +: 3];
        end
    endgenerate

    assign in_ready     = !r_valid || out_ready;
    assign w_accept     = in_valid && in_ready;
    assign w_any_bad    = |w_bad;
    assign w_bad_accept = w_accept && w_any_bad;
    assign w_load       = w_accept && !(c_DROP_EN && w_any_bad);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
            r_mask    <= '0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_payload <= w_payload;
            r_mask    <= w_bad;
        end else if (out_ready) begin
            r_valid   <= 1'b0;
        end
    end

    // A new bad word outranks a coincident clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (w_bad_accept) begin
            r_sticky <= 1'b1;
        end else if (err_clr) begin
            r_sticky <= 1'b0;
        end
    end

`ifdef DECODER_3OF6_ERRCNT_EN
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_bad_accept) begin
            if (err_clr) begin
                r_err_count <= CNT_W'(1);
            end else if (r_err_count != {CNT_W{1'b1}}) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end else if (err_clr) begin
            r_err_count <= '0;
        end
    end

    assign err_count = r_err_count;
`endif

    assign out_valid    = r_valid;
    assign out_payload  = r_payload;
    assign out_err_mask = r_mask;
    assign out_err      = |r_mask;
    assign err_sticky   = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_decoder_3of6_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_3of6_rx
// Brief    : Directed bench for decoder_3of6_rx; one pass-through and one dropping
//            instance checked every cycle against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_decoder_3of6_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] in_code = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;

    logic        rdy0, rdy1, v0, v1, e0, e1, s0, s1;
    logic [23:0] p0, p1;
    logic [7:0]  m0, m1;
`ifdef DECODER_3OF6_ERRCNT_EN
    logic [15:0] c0;
    logic [1:0]  c1;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    decoder_3of6_rx #(.NUM_GROUPS(8), .DROP_ERR(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid),
        .in_ready(rdy0), .out_payload(p0), .out_valid(v0), .out_ready(out_ready),
        .out_err(e0), .out_err_mask(m0), .err_sticky(s0),
`ifdef DECODER_3OF6_ERRCNT_EN
        .err_count(c0),
`endif
        .err_clr(err_clr)
    );

    decoder_3of6_rx #(.NUM_GROUPS(8), .DROP_ERR(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid),
        .in_ready(rdy1), .out_payload(p1), .out_valid(v1), .out_ready(out_ready),
        .out_err(e1), .out_err_mask(m1), .err_sticky(s1),
`ifdef DECODER_3OF6_ERRCNT_EN
        .err_count(c1),
`endif
        .err_clr(err_clr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Payload = upper half of each group, computed arithmetically
    function automatic logic [23:0] f_payload(input logic [47:0] c);
        longint unsigned v = 0;
        for (int g = 0; g < 8; g++)
            v += (((longint'(c) >> (6 * g)) / 8) % 8) << (3 * g);
        return v[23:0];
    endfunction

    function automatic logic [7:0] f_mask(input logic [47:0] c);
        logic [7:0] m = '0;
        for (int g = 0; g < 8; g++) begin
            int wt = 0;
            for (int b = 0; b < 6; b++) wt += int'(c[6*g+b]);
            m[g] = (wt != 3);
        end
        return m;
    endfunction

    function automatic logic [47:0] rep(input logic [5:0] grp);
        logic [47:0] r = '0;
        for (int k = 0; k < 8; k++) r[6*k +: 6] = grp;
        return r;
    endfunction

    // Model: per instance, an output slot, sticky flag and saturating error count
    bit          has[2];
    logic [23:0] mp[2];
    logic [7:0]  mm[2];
    bit          ms[2];
    int          mc[2];

    function automatic bit acc(input int i);
        return in_valid && (!has[i] || out_ready);
    endfunction

    function automatic bit bad_acc(input int i);
        return acc(i) && (f_mask(in_code) != 8'h00);
    endfunction

    function automatic int cmax(input int i);
        return (i == 0) ? 65535 : 3;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                has[i] <= 1'b0; mp[i] <= '0; mm[i] <= '0; ms[i] <= 1'b0; mc[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (acc(i) && !(i == 1 && bad_acc(i))) begin
                    has[i] <= 1'b1;
                    mp[i]  <= f_payload(in_code);
                    mm[i]  <= f_mask(in_code);
                end else if (out_ready) begin
                    has[i] <= 1'b0;
                end
                if (bad_acc(i)) ms[i] <= 1'b1;
                else if (err_clr) ms[i] <= 1'b0;
                if (bad_acc(i))
                    mc[i] <= err_clr ? 1 : ((mc[i] < cmax(i)) ? mc[i] + 1 : mc[i]);
                else if (err_clr)
                    mc[i] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready0", rdy0, !has[0] || out_ready);
        chk("in_ready1", rdy1, !has[1] || out_ready);
        chk("out_valid0", v0, has[0]);
        chk("out_valid1", v1, has[1]);
        chk("payload0", p0, mp[0]);
        chk("payload1", p1, mp[1]);
        chk("mask0", m0, mm[0]);
        chk("mask1", m1, mm[1]);
        chk("err0", e0, mm[0] != 8'h00);
        chk("err1", e1, mm[1] != 8'h00);
        chk("sticky0", s0, ms[0]);
        chk("sticky1", s1, ms[1]);
`ifdef DECODER_3OF6_ERRCNT_EN
        chk("count0", c0, mc[0]);
        chk("count1", c1, mc[1]);
`endif
    end

    task automatic cyc(input logic [47:0] c, input logic v, input logic r, input logic cl);
        in_code = c; in_valid = v; out_ready = r; err_clr = cl;
        @(posedge clk); #1;
    endtask

    logic [47:0] code_a, code_e, g1, g2, g3, bad_all;

    initial begin
        code_a  = rep(6'h2A) & ~(48'h3F << 18);
        code_e  = {6'h15, 6'h2A, 6'h07, 6'h38, 6'h0F, 6'h03, 6'h00, 6'h3F};
        g1      = rep(6'h15);
        g2      = rep(6'h31);
        g3      = rep(6'h0E);
        bad_all = rep(6'h3F);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", v0, 1'b0);
        chk("rst_ready", rdy0, 1'b1);
        chk("rst_sticky", s0, 1'b0);
        chk("rst_payload", p0, 24'h0);

        cyc(rep(6'h38), 1'b1, 1'b1, 1'b0);
        chk("stream_valid", v0, 1'b1);
        chk("stream_payload", p0, 24'hFFFFFF);
        chk("stream_err", e0, 1'b0);
        repeat (3) cyc(rep(6'h38), 1'b1, 1'b1, 1'b0);
        chk("stream_ready", rdy0, 1'b1);

        cyc(code_a, 1'b1, 1'b1, 1'b0);
        chk("grp3_mask", m0, 8'h08);
        chk("grp3_err", e0, 1'b1);
        chk("grp3_payload", p0, 24'hB6D16D);
        chk("grp3_sticky", s0, 1'b1);
        chk("drop_valid", v1, 1'b0);
        chk("drop_sticky", s1, 1'b1);

        cyc(g1, 1'b1, 1'b1, 1'b0);
        chk("hold_load", p0, 24'h492492);
        repeat (3) cyc(g2, 1'b1, 1'b0, 1'b0);
        chk("hold_ready", rdy0, 1'b0);
        chk("hold_valid", v0, 1'b1);
        chk("hold_payload", p0, 24'h492492);
        cyc(g2, 1'b1, 1'b1, 1'b0);
        chk("nogap_valid", v0, 1'b1);
        chk("nogap_payload", p0, 24'hDB6DB6);
        cyc(g2, 1'b0, 1'b1, 1'b0);
        chk("drain_valid", v0, 1'b0);
        chk("drain_payload", p0, 24'hDB6DB6);

        cyc(code_e, 1'b1, 1'b1, 1'b0);
        chk("weights_mask", m0, 8'h0F);
        cyc('x, 1'b0, 1'b1, 1'b1);
        chk("clr_sticky", s0, 1'b0);

        cyc(g1, 1'b1, 1'b1, 1'b0);
        cyc(bad_all, 1'b1, 1'b1, 1'b0);
        cyc(g2, 1'b1, 1'b1, 1'b0);
        cyc(bad_all, 1'b1, 1'b1, 1'b0);
        cyc(g3, 1'b1, 1'b1, 1'b0);
        chk("alt_payload", p1, 24'h249249);
        chk("alt_valid", v1, 1'b1);
        chk("alt_sticky", s1, 1'b1);
`ifdef DECODER_3OF6_ERRCNT_EN
        chk("alt_count1", c1, 2'd2);
        chk("alt_count0", c0, 16'd2);
`endif
        repeat (3) cyc('x, 1'b0, 1'b1, 1'b0);

        cyc(48'h0, 1'b0, 1'b1, 1'b1);
        repeat (5) cyc(48'h0, 1'b1, 1'b1, 1'b0);
`ifdef DECODER_3OF6_ERRCNT_EN
        chk("sat_count1", c1, 2'd3);
        chk("sat_count0", c0, 16'd5);
`endif
        cyc(48'h0, 1'b1, 1'b1, 1'b1);
        chk("clr_bad_sticky", s1, 1'b1);
`ifdef DECODER_3OF6_ERRCNT_EN
        chk("clr_bad_count1", c1, 2'd1);
        chk("clr_bad_count0", c0, 16'd1);
`endif

        cyc(g1, 1'b1, 1'b1, 1'b0);
        cyc(g2, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", v0, 1'b0);
        chk("arst_sticky", s0, 1'b0);
        chk("arst_ready", rdy0, 1'b1);
        chk("arst_payload", p0, 24'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(g3, 1'b1, 1'b1, 1'b0);
        chk("post_rst_valid", v0, 1'b1);
        chk("post_rst_payload", p0, 24'h249249);
        chk("post_rst_mask", m0, 8'h00);
        repeat (2) cyc('x, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
